// File: rtl/program_loader.sv
// Byte-serial program image loader: parses MAGIC/COUNT/payload/CHECKSUM frames into
// instruction-memory word writes and holds the CPU in reset until a verified image is loaded.
module program_loader #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned TIMER_WIDTH  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [31:0] CAPACITY     = 32'd1 << ADDR_WIDTH;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, COUNT_LO, COUNT_HI, PAYLOAD, CHECK, DONE, ERROR
  } state_t;

  state_t                 state, state_next;
  logic [15:0]            count;
  logic [ADDR_WIDTH:0]    word_index;   // one extra bit so a full-capacity count is representable
  logic [1:0]             byte_index;
  logic [7:0]             checksum;
  logic [23:0]            word_asm;
  logic [TIMER_WIDTH-1:0] timer;

  logic        active, restart, word_done, timeout_hit;
  logic [31:0] count_full, words_written;

  assign active        = state inside {COUNT_LO, COUNT_HI, PAYLOAD, CHECK};
  assign count_full    = {16'd0, byte_data, count[7:0]};
  assign words_written = 32'(word_index) + 32'd1;
  assign timeout_hit   = active && !byte_valid && ((32'(timer) + 32'd1) == TIMEOUT_LAST);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    word_done  = 1'b0;
    unique case (state)
      IDLE, DONE, ERROR: begin
        // MAGIC inside a frame is payload; only these states treat it as a restart.
        if (byte_valid && byte_data == MAGIC) begin
          state_next = COUNT_LO;
          restart    = 1'b1;
        end
      end
      COUNT_LO: if (byte_valid) state_next = COUNT_HI;
      COUNT_HI: begin
        if (byte_valid) begin
          if (count_full > CAPACITY)  state_next = ERROR;
          else if (count_full == '0)  state_next = CHECK;
          else                        state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (byte_valid && byte_index == 2'd3) begin
          word_done = 1'b1;
          if (words_written == 32'(count)) state_next = CHECK;
        end
      end
      CHECK: if (byte_valid) state_next = (byte_data == checksum) ? DONE : ERROR;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = ERROR;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      word_index     <= '0;
      byte_index     <= '0;
      checksum       <= '0;
      word_asm       <= '0;
      timer          <= '0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      cpu_run        <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state     <= state_next;
      mem_write <= word_done;
      // Status flags decode the registered state, so they trail it by one cycle.
      cpu_run   <= (state == DONE);
      done      <= (state == DONE);
      error     <= (state == ERROR);

      if (restart) begin
        word_index <= '0;
        byte_index <= '0;
        checksum   <= '0;
        timer      <= '0;
      end else if (active) begin
        timer <= byte_valid ? '0 : timer + TIMER_WIDTH'(1);
      end

      if (byte_valid) begin
        if (state == COUNT_LO) count[7:0]  <= byte_data;
        if (state == COUNT_HI) count[15:8] <= byte_data;
        if (state == PAYLOAD) begin
          checksum   <= checksum + byte_data;
          byte_index <= byte_index + 2'd1;
          word_asm   <= {byte_data, word_asm[23:8]};
          if (word_done) begin
            mem_address    <= word_index[ADDR_WIDTH-1:0];
            mem_write_data <= {byte_data, word_asm};
            word_index     <= word_index + (ADDR_WIDTH+1)'(1);
          end
        end
      end
    end
  end

endmodule
